mm_top: RTL and testbench

// - Suffix-array builder for the BWT datapath (Manber-Myers prefix doubling).
// - Takes an N-symbol string plus an initial suffix-index list and returns suffix start

---
 rtl/mm_top.sv | 162 ++++++++++++++++
 tb/tb_mm_top.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mm_top.sv
// Manber-Myers prefix-doubling suffix-array builder feeding the BWT stage.
// Optional MM_TOP_EARLY_EXIT_EN: stop as soon as every suffix rank is unique.
module mm_top #(
  parameter int N        = 8,
  parameter int MAX_ITER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_string [N-1:0],
  input  logic [7:0] suffixes     [N-1:0],
  input  logic       start_sort,
  output logic [7:0] suffixes_out [N-1:0],
  output logic       sort_done
);

  localparam int RW = 9;
  localparam int KW = 2 * RW;
  localparam int HW = 16;
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, KEYS, SORT, RANK, CHECK, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      sa       [N-1:0];
  logic [RW-1:0]   rank     [N-1:0];
  logic [KW-1:0]   key      [N-1:0];
  logic [HW-1:0]   h;
  logic [CW-1:0]   round;
  logic [CW-1:0]   pass;

  logic [KW-1:0]   key_new  [N-1:0];
  logic [7:0]      sa_swp   [N-1:0];
  logic [KW-1:0]   key_swp  [N-1:0];
  logic [RW-1:0]   nr       [N-1:0];
  logic [RW-1:0]   rank_new [N-1:0];
  logic            last_round;
  logic            all_unique;

  assign last_round = (round == CW'(MAX_ITER - 1));

`ifdef MM_TOP_EARLY_EXIT_EN
  assign all_unique = (nr[N-1] == RW'(N));
`else
  assign all_unique = 1'b0;
`endif

  // Key of each slot: (rank of suffix, rank of suffix+h); positions past the end read as 0.
  always_comb begin
    logic [HW-1:0] tail;
    logic [RW-1:0] hi, lo;
    tail = '0;
    hi   = '0;
    lo   = '0;
    for (int k = 0; k < N; k++) begin
      tail = HW'(sa[k]) + h;
      hi   = '0;
      lo   = '0;
      for (int i = 0; i < N; i++) begin
        if (sa[k] == 8'(i)) hi = rank[i];
        if (tail == HW'(i)) lo = rank[i];
      end
      key_new[k] = {hi, lo};
    end
  end

  // One odd-even transposition pass; pairs start on the parity of the pass number.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      sa_swp[k]  = sa[k];
      key_swp[k] = key[k];
    end
    for (int j = 0; j < N - 1; j++) begin
      if ((j[0] == pass[0]) && (key[j] > key[j+1])) begin
        sa_swp[j]    = sa[j+1];
        sa_swp[j+1]  = sa[j];
        key_swp[j]   = key[j+1];
        key_swp[j+1] = key[j];
      end
    end
  end

  // Dense re-ranking over the sorted keys, scattered back to text positions.
  always_comb begin
    logic [RW-1:0] acc;
    acc   = RW'(1);
    nr[0] = acc;
    for (int k = 1; k < N; k++) begin
      acc   = acc + RW'(key[k] != key[k-1]);
      nr[k] = acc;
    end
    for (int i = 0; i < N; i++) begin
      rank_new[i] = rank[i];
      for (int k = 0; k < N; k++) begin
        if (sa[k] == 8'(i)) rank_new[i] = nr[k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_sort) state_nxt = KEYS;
      KEYS:    state_nxt = SORT;
      SORT:    if (pass == CW'(N - 1)) state_nxt = RANK;
      RANK:    state_nxt = CHECK;
      CHECK:   state_nxt = (last_round || all_unique) ? DONE : KEYS;
      DONE:    if (start_sort) state_nxt = KEYS;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sort_done <= 1'b0;
      h         <= '0;
      round     <= '0;
      pass      <= '0;
      for (int k = 0; k < N; k++) begin
        sa[k]           <= '0;
        rank[k]         <= '0;
        key[k]          <= '0;
        suffixes_out[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            suffixes_out <= sa;
            sort_done    <= 1'b1;
          end
          if (start_sort) begin
            for (int k = 0; k < N; k++) begin
              sa[k]   <= suffixes[k];
              rank[k] <= RW'(input_string[k]) + RW'(1);
            end
            h         <= HW'(1);
            round     <= '0;
            sort_done <= 1'b0;
          end
        end
        KEYS: begin
          key  <= key_new;
          pass <= '0;
        end
        SORT: begin
          sa   <= sa_swp;
          key  <= key_swp;
          pass <= pass + CW'(1);
        end
        RANK:  rank <= rank_new;
        CHECK: begin
          round <= round + CW'(1);
          h     <= h << 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_top.sv
// Directed bench for mm_top: fixed strings with hand-computed suffix arrays and latency.
module tb_mm_top;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_sort = 1'b0;
  logic [7:0] input_string [N-1:0];
  logic [7:0] suffixes     [N-1:0];
  logic [7:0] suffixes_out [N-1:0];
  logic       sort_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  int exp_miss [8] = '{7, 4, 1, 0, 6, 3, 5, 2};
  int exp_aaaa [8] = '{7, 6, 5, 4, 3, 2, 1, 0};
  int perm     [8] = '{3, 7, 0, 5, 1, 6, 2, 4};
`ifdef MM_TOP_EARLY_EXIT_EN
  int exp_lat = 23;
`else
  int exp_lat = 45;
`endif

  mm_top #(.N(N), .MAX_ITER(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_string (input_string),
    .suffixes     (suffixes),
    .start_sort   (start_sort),
    .suffixes_out (suffixes_out),
    .sort_done    (sort_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < N; i++) input_string[i] = s[i];
  endtask

  task automatic load_ident();
    for (int i = 0; i < N; i++) suffixes[i] = 8'(i);
  endtask

  task automatic load_perm();
    for (int i = 0; i < N; i++) suffixes[i] = 8'(perm[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_sort = 1'b1;
    @(negedge clk);
    start_sort = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (sort_done !== 1'b1 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done_reached", int'(sort_done === 1'b1), 1);
  endtask

  task automatic chk_result(input string tag, input int e [8]);
    for (int k = 0; k < N; k++) chk($sformatf("%s[%0d]", tag, k), int'(suffixes_out[k]), e[k]);
  endtask

  initial begin
    load_str("mississ$");
    load_ident();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(sort_done), 0);
    for (int k = 0; k < N; k++) chk($sformatf("rst_out[%0d]", k), int'(suffixes_out[k]), 0);
    @(negedge clk);
    rst = 1'b0;

    pulse_start();
    wait_done(cyc);
    chk("miss_latency", cyc, exp_lat);
    chk_result("miss", exp_miss);

    load_str("aaaaaaa$");
    pulse_start();
    wait_done(cyc);
    chk_result("aaaa", exp_aaaa);

    load_str("mississ$");
    load_perm();
    pulse_start();
    wait_done(cyc);
    chk("perm_latency", cyc, exp_lat);
    chk_result("perm", exp_miss);

    pulse_start();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_done", int'(sort_done), 0);
    for (int k = 0; k < N; k++) chk($sformatf("midrst_out[%0d]", k), int'(suffixes_out[k]), 0);
    @(negedge clk);
    rst = 1'b0;
    load_ident();
    pulse_start();
    wait_done(cyc);
    chk("after_rst_latency", cyc, exp_lat);
    chk_result("after_rst", exp_miss);

    pulse_start();
    cyc = 0;
    while (sort_done !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) begin
        load_str("aaaaaaa$");
        start_sort = 1'b1;
      end else begin
        start_sort = 1'b0;
      end
    end
    chk("restart_done", int'(sort_done === 1'b1), 1);
    chk("restart_latency", cyc, exp_lat);
    chk_result("restart", exp_miss);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
